dcache_l1: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache that sits between the RISC-V pipeline MEM stage and the L2 data cache.
- Converts 32-bit word accesses from the processor into 128-bit block requests on the L2-facing port.
- That port uses the same req/ready protocol the L2 presents upstream: 28-bit block address, 128-bit data, single-cycle ready.
- Stalls the pipeline on a miss until the block is resident.

---
 rtl/dcache_l1_pkg.sv | 12 +
 rtl/dcache_l1_array.sv | 58 +++++
 rtl/dcache_l1.sv | 127 ++++++++++++
 tb/tb_dcache_l1.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_l1_pkg.sv
// dcache_l1_pkg: shared widths and FSM state encoding for the L1 data cache
package dcache_l1_pkg;
    localparam int ADDR_W       = 30;
    localparam int BLOCK_ADDR_W = 28;
    localparam int WORD_W       = 32;
    localparam int BLOCK_W      = 128;
    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        ALLOCATE  = 2'd1,
        WRITEBACK = 2'd2
    } state_t;
endpackage

// File: rtl/dcache_l1_array.sv
// dcache_l1_array: valid/dirty/tag/data line storage with async clear,
// one combinational read index, a full-line fill port and a word-merge port.
module dcache_l1_array
    import dcache_l1_pkg::*;
#(
    parameter int NUM_OF_BLOCK = 8,
    parameter int INDEX_W      = 3,
    parameter int TAG_W        = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] index,
    input  logic [1:0]         word,
    input  logic               fill_en,
    input  logic               merge_en,
    input  logic               clean_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data,
    input  logic [WORD_W-1:0]  merge_data,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data
);
    logic [NUM_OF_BLOCK-1:0] valid;
    logic [NUM_OF_BLOCK-1:0] dirty;
    logic [TAG_W-1:0]        tags [NUM_OF_BLOCK];
    logic [BLOCK_W-1:0]      data [NUM_OF_BLOCK];

    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_tag   = tags[index];
    assign rd_data  = data[index];

    // Only the status bits need clearing; tag/data are qualified by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (merge_en) begin
            dirty[index] <= 1'b1;
        end else if (clean_en) begin
            dirty[index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[index] <= fill_tag;
            data[index] <= fill_data;
        end else if (merge_en) begin
            data[index][word*WORD_W +: WORD_W] <= merge_data;
        end
    end
endmodule

// File: rtl/dcache_l1.sv
// dcache_l1: direct-mapped write-back/write-allocate L1 D-cache with 128-bit L2 port.
// Define DCACHE_L1_PERF_CNT_EN to add hit_cnt/miss_cnt performance counters.
module dcache_l1
    import dcache_l1_pkg::*;
#(
    parameter int NUM_OF_BLOCK = 8,
    parameter int INDEX_W      = 3,
    parameter int TAG_W        = 25
) (
    input  logic                    clk,
    input  logic                    proc_reset,
    input  logic                    proc_read,
    input  logic                    proc_write,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic [WORD_W-1:0]       proc_wdata,
    output logic [WORD_W-1:0]       proc_rdata,
    output logic                    proc_stall,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [BLOCK_ADDR_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]      mem_wdata,
    input  logic [BLOCK_W-1:0]      mem_rdata,
    input  logic                    mem_ready
`ifdef DCACHE_L1_PERF_CNT_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);
    state_t             state, next;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         word;
    logic               req, hit;
    logic               rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [BLOCK_W-1:0] rd_data;
    logic               fill_en, merge_en, clean_en;

    assign index = proc_addr[INDEX_W+1:2];
    assign tag   = proc_addr[ADDR_W-1:INDEX_W+2];
    assign word  = proc_addr[1:0];
    assign req   = proc_read ^ proc_write;
    assign hit   = rd_valid && rd_tag == tag;

    dcache_l1_array #(
        .NUM_OF_BLOCK(NUM_OF_BLOCK),
        .INDEX_W     (INDEX_W),
        .TAG_W       (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (proc_reset),
        .index     (index),
        .word      (word),
        .fill_en   (fill_en),
        .merge_en  (merge_en),
        .clean_en  (clean_en),
        .fill_tag  (tag),
        .fill_data (mem_rdata),
        .merge_data(proc_wdata),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) state <= COMPARE;
        else            state <= next;
    end

    // Outputs are forced idle while reset is held so mem requests drop at once.
    always_comb begin
        next       = state;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_en    = 1'b0;
        merge_en   = 1'b0;
        clean_en   = 1'b0;
        if (!proc_reset)
            case (state)
                COMPARE: begin
                    proc_stall = req && !hit;
                    proc_rdata = (req && hit && proc_read) ? rd_data[word*WORD_W +: WORD_W] : '0;
                    merge_en   = req && hit && proc_write;
                    next       = (!req || hit) ? COMPARE : ((rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE);
                end
                WRITEBACK: begin
                    proc_stall = 1'b1;
                    mem_write  = 1'b1;
                    mem_addr   = {rd_tag, index};
                    mem_wdata  = rd_data;
                    clean_en   = mem_ready;
                    next       = mem_ready ? ALLOCATE : WRITEBACK;
                end
                ALLOCATE: begin
                    proc_stall = 1'b1;
                    mem_read   = 1'b1;
                    mem_addr   = proc_addr[ADDR_W-1:2];
                    fill_en    = mem_ready;
                    next       = mem_ready ? COMPARE : ALLOCATE;
                end
                default: next = COMPARE;
            endcase
    end

`ifdef DCACHE_L1_PERF_CNT_EN
    logic after_fill;

    // The COMPARE cycle right after a fill completes a miss, so it is not a hit.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            after_fill <= 1'b0;
        end else begin
            after_fill <= fill_en;
            if (state == COMPARE && req && hit && !after_fill) hit_cnt <= hit_cnt + 32'd1;
            if (state == COMPARE && next != COMPARE) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_l1.sv
// tb_dcache_l1: directed stimulus against a transaction-level cache/L2 model with per-cycle output checks.
module tb_dcache_l1;
    localparam int L2_LAT = 3;

    logic         clk, proc_reset, proc_read, proc_write, proc_stall;
    logic         mem_read, mem_write, mem_ready;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
`ifdef DCACHE_L1_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    dcache_l1 dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .proc_read (proc_read),
        .proc_write(proc_write),
        .proc_addr (proc_addr),
        .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata),
        .proc_stall(proc_stall),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef DCACHE_L1_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // L2 backing store: preloaded blocks plus an address-derived default pattern.
    logic [127:0] l2 [logic [27:0]];

    function automatic logic [127:0] l2_get(input logic [27:0] a);
        if (l2.exists(a)) return l2[a];
        return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
    endfunction

    int lat_cnt;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        lat_cnt   = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (proc_reset || !(mem_read || mem_write)) lat_cnt = 0;
            else begin
                lat_cnt++;
                if (lat_cnt == L2_LAT) begin
                    mem_ready = 1'b1;
                    lat_cnt   = 0;
                    if (mem_read) mem_rdata = l2_get(mem_addr);
                    else          l2[mem_addr] = mem_wdata;
                end
            end
        end
    end

    // Bus activity monitor used by the directed checks.
    int           mem_cycles = 0, wb_cycles = 0;
    logic [27:0]  last_rd_addr = '0, last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;
    always @(negedge clk) begin
        #1;
        if (mem_read || mem_write) mem_cycles++;
        if (mem_read) last_rd_addr = mem_addr;
        if (mem_write) begin
            wb_cycles++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
        end
    end

    // Reference model: cache contents plus outstanding write-back / fill obligations.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [24:0]  m_tag   [8];
    logic [127:0] m_data  [8];
    bit           pend_wb = 0, pend_fill = 0, just_filled = 0;
    int unsigned  m_hits = 0, m_miss = 0;

    always @(negedge clk) begin
        logic [2:0]   idx;
        logic [24:0]  tg;
        logic [1:0]   wd;
        bit           rq, ht, jf;
        logic         e_stall, e_mr, e_mw;
        logic [31:0]  e_rdata;
        logic [27:0]  e_addr;
        logic [127:0] e_wdata;
        idx = proc_addr[4:2];
        tg  = proc_addr[29:5];
        wd  = proc_addr[1:0];
        rq  = proc_read ^ proc_write;
        if (proc_reset) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 0;
                m_dirty[i] = 0;
            end
            pend_wb = 0; pend_fill = 0; just_filled = 0; m_hits = 0; m_miss = 0;
        end
        ht = m_valid[idx] && m_tag[idx] == tg;
        e_stall = 0; e_mr = 0; e_mw = 0; e_rdata = '0; e_addr = '0; e_wdata = '0;
        if (proc_reset) ;
        else if (pend_wb) begin
            e_stall = 1; e_mw = 1; e_addr = {m_tag[idx], idx}; e_wdata = m_data[idx];
        end else if (pend_fill) begin
            e_stall = 1; e_mr = 1; e_addr = proc_addr[29:2];
        end else if (rq && ht) begin
            e_rdata = proc_read ? m_data[idx][wd*32 +: 32] : '0;
        end else if (rq) e_stall = 1;
        chk("proc_stall", proc_stall, e_stall);
        chk("proc_rdata", proc_rdata, e_rdata);
        chk("mem_read", mem_read, e_mr);
        chk("mem_write", mem_write, e_mw);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
`ifdef DCACHE_L1_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_miss);
`endif
        if (!proc_reset) begin
            jf = 0;
            if (pend_wb) begin
                if (mem_ready) begin
                    m_dirty[idx] = 0;
                    pend_wb = 0;
                end
            end else if (pend_fill) begin
                if (mem_ready) begin
                    m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tg;
                    m_data[idx] = l2_get(proc_addr[29:2]);
                    pend_fill = 0; jf = 1;
                end
            end else if (rq && ht) begin
                if (!just_filled) m_hits++;
                if (proc_write) begin
                    m_data[idx][wd*32 +: 32] = proc_wdata;
                    m_dirty[idx] = 1;
                end
            end else if (rq) begin
                m_miss++;
                pend_fill = 1;
                pend_wb = m_valid[idx] && m_dirty[idx];
            end
            just_filled = jf;
        end
    end

    // Issue one access and hold it until the cache stops stalling.
    task automatic acc(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int stalls);
        bit done = 0;
        @(posedge clk);
        #1;
        proc_read = r; proc_write = w; proc_addr = a; proc_wdata = d;
        stalls = 0;
        rd = '0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!proc_stall) begin
                done = 1;
                rd = proc_rdata;
            end else stalls++;
        end
        if (!done) chk("stall_timeout", 1'b1, 1'b0);
        #2;
    endtask

    logic [31:0] rd;
    int          st, snap;

    initial begin
        l2[28'h4]  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        l2[28'h24] = 128'h44444444_33333333_22222222_11111111;
        proc_reset = 1; proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
        repeat (2) @(posedge clk);
        #1 proc_reset = 0;
        @(negedge clk);
        chk("reset_stall", proc_stall, 1'b0);
        chk("reset_rdata", proc_rdata, 32'h0);
        chk("reset_mem_read", mem_read, 1'b0);

        acc(1, 0, 30'h10, 0, rd, st);
        chk("clean_miss_stalls", st, 4);
        chk("clean_miss_data", rd, 32'hAAAAAAAA);
        chk("fill_addr", last_rd_addr, 28'h4);
        acc(1, 0, 30'h10, 0, rd, st);
        chk("reread_stalls", st, 0);
        chk("reread_data", rd, 32'hAAAAAAAA);

        snap = mem_cycles;
        acc(0, 1, 30'h11, 32'h12345678, rd, st);
        chk("write_hit_stalls", st, 0);
        chk("write_hit_no_mem", mem_cycles, snap);
        acc(1, 0, 30'h11, 0, rd, st);
        chk("write_hit_readback", rd, 32'h12345678);

        acc(1, 0, 30'h91, 0, rd, st);
        chk("dirty_miss_stalls", st, 7);
        chk("dirty_miss_data", rd, 32'h22222222);
        chk("wb_addr", last_wb_addr, 28'h4);
        chk("wb_word1", last_wb_data[63:32], 32'h12345678);
        chk("dirty_fill_addr", last_rd_addr, 28'h24);

        snap = wb_cycles;
        acc(0, 1, 30'h52, 32'hCAFEF00D, rd, st);
        chk("write_miss_stalls", st, 4);
        chk("write_miss_no_wb", wb_cycles, snap);
        acc(1, 0, 30'h50, 0, rd, st);
        chk("write_miss_fill_word", rd, 32'h00000014);
        acc(1, 0, 30'h52, 0, rd, st);
        chk("write_miss_merged", rd, 32'hCAFEF00D);
        acc(1, 0, 30'h10, 0, rd, st);
        chk("evict_written_stalls", st, 7);
        chk("evict_wb_addr", last_wb_addr, 28'h14);
        chk("evict_wb_word2", last_wb_data[95:64], 32'hCAFEF00D);
        chk("evict_refill_data", rd, 32'hAAAAAAAA);

        snap = mem_cycles;
        acc(1, 1, 30'h10, 32'hFFFFFFFF, rd, st);
        chk("both_high_stalls", st, 0);
        chk("both_high_rdata", rd, 32'h0);
        chk("both_high_no_mem", mem_cycles, snap);
`ifdef DCACHE_L1_PERF_CNT_EN
        chk("hit_cnt_literal", hit_cnt, 32'd5);
        chk("miss_cnt_literal", miss_cnt, 32'd4);
`endif
        acc(1, 0, 30'h10, 0, rd, st);
        chk("after_both_high_stalls", st, 0);
        chk("after_both_high_data", rd, 32'hAAAAAAAA);

        @(posedge clk);
        #1 proc_read = 1; proc_write = 0; proc_addr = 30'h200;
        @(posedge clk);
        #1 chk("alloc_before_reset", mem_read, 1'b1);
        proc_reset = 1;
        #1 chk("reset_drops_mem_read", mem_read, 1'b0);
        chk("reset_drops_stall", proc_stall, 1'b0);
        @(posedge clk);
        #1 proc_reset = 0; proc_read = 0;
        acc(1, 0, 30'h200, 0, rd, st);
        chk("rerequest_miss_stalls", st, 4);
        chk("rerequest_data", rd, 32'h00000080);
        acc(1, 0, 30'h10, 0, rd, st);
        chk("post_reset_clean_miss", st, 4);

        @(posedge clk);
        #1 proc_read = 0; proc_write = 0;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
